div_sched: RTL and testbench

Controller that shares one iterative 32-bit divide core between two requesters (integer pipe slot 0 and slot 1) in the dynamic-pipeline CPU. It arbitrates round-robin and handles signed/unsigned operand conditioning. It short-circuits divide-by-zero and signed overflow, sequences the core through its iterations, and holds the result until the consumer takes it. It obeys the pipeline's `cpu_stall` and `flush`.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_core.sv | 80 ++++++++
 rtl/div_sched.sv | 162 ++++++++++++++++
 tb/tb_div_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_pkg: shared types and constants for the divide scheduler and core.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package div_pkg;

    localparam int DIV_DW   = 32;
    localparam int DIV_TAGW = 4;
    localparam int ITER     = 32;

    localparam logic [DIV_DW-1:0] DIV0_Q  = {DIV_DW{1'b1}};
    localparam logic [DIV_DW-1:0] INT_MIN = {1'b1, {(DIV_DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negate when neg is set.
    function automatic logic [DIV_DW-1:0] cond_neg(input logic neg, input logic [DIV_DW-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_core: unsigned radix-2 restoring divider, one iteration per cycle.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module div_core
    import div_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          kill,
    input  logic          stall,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          finish,
    output logic [DW-1:0] uq,
    output logic [DW-1:0] ur
);

    logic [5:0]      count_q, count_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [DW-1:0]   dsr_q, dsr_d;
    logic            busy_q, busy_d;
    logic [DW:0]     trial;

    // acc holds {partial remainder, dividend/quotient}; the shifted remainder
    // needs DW+1 bits, so the trial subtract includes the bit about to shift out.
    always_comb begin
        count_d = count_q;
        acc_d   = acc_q;
        dsr_d   = dsr_q;
        busy_d  = busy_q;
        trial   = acc_q[2*DW-1:DW-1] - {1'b0, dsr_q};
        if (kill) begin
            busy_d  = 1'b0;
            count_d = 6'd0;
        end else if (start) begin
            busy_d  = 1'b1;
            count_d = 6'(ITER);
            acc_d   = {{DW{1'b0}}, dividend};
            dsr_d   = divisor;
        end else if (busy_q && !stall) begin
            if (count_q != 6'd0) begin
                count_d = count_q - 6'd1;
                if (!trial[DW]) begin
                    acc_d = {trial[DW-1:0], acc_q[DW-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*DW-2:0], 1'b0};
                end
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 6'd0;
            acc_q   <= '0;
            dsr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            dsr_q   <= dsr_d;
            busy_q  <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign finish = busy_q && !stall && !kill && (count_q == 6'd0);
    assign uq     = acc_q[DW-1:0];
    assign ur     = acc_q[2*DW-1:DW];

endmodule
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_sched: round-robin sharing of one divide core between two requesters |
// | with sign conditioning, fast paths, stall and flush handling.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module div_sched
    import div_pkg::*;
#(
    parameter int DW   = DIV_DW,
    parameter int TAGW = DIV_TAGW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_stall,
    input  logic              flush,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*DW-1:0]   req_dividend,
    input  logic [2*DW-1:0]   req_divisor,
    input  logic [1:0]        req_signed,
    input  logic [2*TAGW-1:0] req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_q,
    output logic [DW-1:0]     rsp_r,
    output logic [TAGW-1:0]   rsp_tag,
    output logic              rsp_src
);

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            src_q, src_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [DW-1:0]   rem_q, rem_d;

    logic            win;
    logic [DW-1:0]   sel_a, sel_b, mag_a, mag_b;
    logic [TAGW-1:0] sel_tag;
    logic            sel_sgn, sa, sb;
    logic [1:0]      grant;
    logic            core_start, core_kill, core_busy, core_finish;
    logic [DW-1:0]   core_uq, core_ur;

    // Winner is the favoured slot if it asks, otherwise the other one.
    assign win     = req_valid[rr_q] ? rr_q : ~rr_q;
    assign sel_a   = win ? req_dividend[2*DW-1:DW] : req_dividend[DW-1:0];
    assign sel_b   = win ? req_divisor[2*DW-1:DW]  : req_divisor[DW-1:0];
    assign sel_tag = win ? req_tag[2*TAGW-1:TAGW]  : req_tag[TAGW-1:0];
    assign sel_sgn = req_signed[win];
    assign sa      = sel_sgn & sel_a[DW-1];
    assign sb      = sel_sgn & sel_b[DW-1];
    assign mag_a   = cond_neg(sa, sel_a);
    assign mag_b   = cond_neg(sb, sel_b);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        tag_d      = tag_q;
        src_d      = src_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        grant      = 2'b00;
        core_start = 1'b0;
        core_kill  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && !cpu_stall && (req_valid != 2'b00)) begin
                    grant     = win ? 2'b10 : 2'b01;
                    rr_d      = ~win;
                    tag_d     = sel_tag;
                    src_d     = win;
                    neg_quo_d = sel_sgn & (sa ^ sb);
                    neg_rem_d = sa;
                    if (sel_b == '0) begin
                        quo_d   = DIV0_Q;
                        rem_d   = sel_a;
                        state_d = ST_DONE;
                    end else if (sel_sgn && (sel_a == INT_MIN) && (sel_b == DIV0_Q)) begin
                        quo_d   = INT_MIN;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        core_start = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    core_kill = 1'b1;
                    state_d   = ST_IDLE;
                end else if (core_busy && core_finish) begin
                    quo_d   = cond_neg(neg_quo_q, core_uq);
                    rem_d   = cond_neg(neg_rem_q, core_ur);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush) begin
                    core_kill = 1'b1;
                    state_d   = ST_IDLE;
                end else if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            tag_q     <= '0;
            src_q     <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            tag_q     <= tag_d;
            src_q     <= src_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
        end
    end

    div_core #(
        .DW (DW)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .start    (core_start),
        .kill     (core_kill),
        .stall    (cpu_stall),
        .dividend (mag_a),
        .divisor  (mag_b),
        .busy     (core_busy),
        .finish   (core_finish),
        .uq       (core_uq),
        .ur       (core_ur)
    );

    assign req_ready = grant;
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_q     = quo_q;
    assign rsp_r     = rem_q;
    assign rsp_tag   = tag_q;
    assign rsp_src   = src_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_div_sched: directed self-checking bench for div_sched.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_div_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_stall;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_dividend;
    logic [63:0] req_divisor;
    logic [1:0]  req_signed;
    logic [7:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_q;
    logic [31:0] rsp_r;
    logic [3:0]  rsp_tag;
    logic        rsp_src;

    int n_tests = 0;
    int n_fail  = 0;

    div_sched #(
        .DW   (32),
        .TAGW (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_stall    (cpu_stall),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_signed   (req_signed),
        .req_tag      (req_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_q        (rsp_q),
        .rsp_r        (rsp_r),
        .rsp_tag      (rsp_tag),
        .rsp_src      (rsp_src)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge; returns at the negedge right after the accept edge.
    task automatic start_op(input int slot, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic [3:0] tag, input string name);
        int k;
        req_valid                 = 2'b00;
        req_valid[slot]           = 1'b1;
        req_dividend[slot*32 +: 32] = a;
        req_divisor[slot*32 +: 32]  = b;
        req_signed[slot]          = sgn;
        req_tag[slot*4 +: 4]      = tag;
        #1;
        k = 0;
        while (!req_ready[slot] && k < 20) begin
            @(negedge clock);
            #1;
            k++;
        end
        check({name, "_grant_wait"}, k, 0);
        @(posedge clock);
        @(negedge clock);
        req_valid = 2'b00;
    endtask

    task automatic run_op(input int slot, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [3:0] tag,
                          input logic [31:0] eq, input logic [31:0] er,
                          input int elat, input int stall_at, input string name);
        int lat;
        start_op(slot, a, b, sgn, tag, name);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            if (lat == stall_at)     cpu_stall = 1'b1;
            if (lat == stall_at + 3) cpu_stall = 1'b0;
            @(negedge clock);
            lat++;
        end
        cpu_stall = 1'b0;
        check({name, "_lat"}, lat, elat);
        check({name, "_q"},   rsp_q, eq);
        check({name, "_r"},   rsp_r, er);
        check({name, "_tag"}, {rsp_src, rsp_tag}, {slot[0], tag});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gsrc[4];
        int gcyc[4];
        int ngrant;
        int n;
        int lowfrom;
        int seen;

        reset        = 1'b1;
        cpu_stall    = 1'b0;
        flush        = 1'b0;
        req_valid    = 2'b00;
        req_dividend = '0;
        req_divisor  = '0;
        req_signed   = 2'b00;
        req_tag      = '0;
        rsp_ready    = 1'b1;
        #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_outs", {rsp_valid, rsp_src, rsp_tag, rsp_q, rsp_r}, '0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Both slots request divide-by-zero continuously; rr starts at 0.
        @(negedge clock);
        req_valid    = 2'b11;
        req_dividend = {32'd9, 32'd5};
        req_divisor  = '0;
        req_tag      = {4'hB, 4'hA};
        ngrant  = 0;
        n       = 0;
        lowfrom = -100;
        while (ngrant < 4 && n < 60) begin
            #1;
            if ((req_ready & req_valid) != 2'b00) begin
                gsrc[ngrant] = int'(req_ready[1]);
                gcyc[ngrant] = n;
                ngrant++;
                if (ngrant == 3) lowfrom = n + 1;
            end
            rsp_ready = !(n >= lowfrom && n < lowfrom + 5);
            @(negedge clock);
            n++;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        check("arb_count", ngrant, 4);
        check("arb_src", {gsrc[0][0], gsrc[1][0], gsrc[2][0], gsrc[3][0]}, 4'b0101);
        check("arb_gap01", gcyc[1] - gcyc[0], 2);
        check("arb_gap12", gcyc[2] - gcyc[1], 2);
        check("arb_gap23_held", gcyc[3] - gcyc[2], 7);

        repeat (3) @(negedge clock);
        req_valid = 2'b01;
        flush = 1'b1;
        #1 check("flush_blocks_grant", req_ready, 2'b00);
        flush = 1'b0;
        cpu_stall = 1'b1;
        #1 check("stall_blocks_grant", req_ready, 2'b00);
        cpu_stall = 1'b0;
        #1 check("idle_grant", req_ready, 2'b01);
        req_valid = 2'b00;
        @(negedge clock);

        run_op(0, 32'd100, 32'd7, 1'b0, 4'h5, 32'd14, 32'd2, 34, -1, "u100_7");
        @(negedge clock);
        run_op(1, 32'hFFFFFFF9, 32'd2, 1'b1, 4'h9, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, -1, "sm7_2");
        @(negedge clock);
        run_op(0, 32'd7, 32'hFFFFFFFE, 1'b1, 4'h3, 32'hFFFFFFFD, 32'd1, 34, -1, "s7_m2");
        @(negedge clock);
        run_op(1, 32'd5, 32'd0, 1'b0, 4'hC, 32'hFFFFFFFF, 32'd5, 1, -1, "div0");
        @(negedge clock);
        run_op(0, 32'hFFFFFFF9, 32'd0, 1'b1, 4'h1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1, -1, "sdiv0");
        @(negedge clock);
        run_op(0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 4'h7, 32'h80000000, 32'd0, 1, -1, "ovf");
        @(negedge clock);
        run_op(1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 4'h8, 32'd0, 32'h80000000, 34, -1, "u_nonovf");
        @(negedge clock);
        run_op(0, 32'hFFFFFFFF, 32'd1, 1'b0, 4'hE, 32'hFFFFFFFF, 32'd0, 34, -1, "umax_1");
        @(negedge clock);
        run_op(0, 32'd100, 32'd7, 1'b0, 4'h6, 32'd14, 32'd2, 37, 6, "stall3");
        @(negedge clock);

        // Flush seen at edge T+10, then a fresh request right away.
        start_op(0, 32'd100, 32'd7, 1'b0, 4'h2, "flush_op");
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_no_rsp", rsp_valid, 1'b0);
        run_op(1, 32'd20, 32'd3, 1'b0, 4'hD, 32'd6, 32'd2, 34, -1, "after_flush");
        @(negedge clock);

        // Asynchronous reset mid-RUN.
        start_op(1, 32'd100, 32'd7, 1'b0, 4'h4, "reset_op");
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_outs", {rsp_valid, rsp_src, rsp_tag, rsp_q, rsp_r}, '0);
        check("midrst_ready", req_ready, 2'b00);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (45) begin
            @(negedge clock);
            if (rsp_valid) seen++;
        end
        check("midrst_no_rsp", seen, 0);
        run_op(0, 32'd7, 32'hFFFFFFFE, 1'b1, 4'hA, 32'hFFFFFFFD, 32'd1, 34, -1, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
